imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory responder on the fetch interface: takes word fetch requests (PC address) and returns the instruction word, its address and fault flags to decode.
- Word-organised synchronous-read array, one-cycle read stage, then a small response FIFO with ready/valid toward decode.
- Flush drops stale in-flight and queued fetches on a branch/jal/jalr redirect.
- A program-load port fills the array before run.

Parameters:
- DEPTH, 1024, instruction words in the array; power of two; byte span DEPTH*4.
- AW, 10, word-index width, log2(DEPTH).
- FIFO_DEPTH, 4, response FIFO entries; power of two, at least 2.
- NOP_INSTR, 32'h00000013, word returned on any fault (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address of the fetch.
- req_ready  out  1  responder accepts a request this cycle.
- flush  in  1  redirect: discard all older in-flight and queued responses.
- resp_valid  out  1  FIFO head valid.
- resp_ready  in  1  decode consumes the head.
- resp_addr  out  32  byte address of the head response.
- resp_instr  out  32  instruction word, or NOP_INSTR on fault.
- resp_misaligned  out  1  head request had req_addr[1:0] != 0.
- resp_oob  out  1  head request had req_addr >= DEPTH*4.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  AW  word index for the load.
- prog_data  in  32  word to write.

Behaviour:
- Reset (rst=0, async): FIFO count, pointers and in-flight valid cleared. resp_valid=0, req_ready=1. resp_addr, resp_instr and the flags read as 0. Array contents are not reset.
- Accept: req_valid and req_ready at edge E0. At E0:
  - array read at req_addr[AW+1:2] into the stage register;
  - stage captures addr, misaligned = |req_addr[1:0], oob = req_addr[31:AW+2] != 0;
  - inflight=1.
- Stage drain: at E1 the stage entry is pushed into the FIFO and inflight clears unless a new request is accepted at E1. Fault entries store NOP_INSTR.
- Latency: a request accepted in cycle t shows resp_valid=1 in cycle t+2 when the FIFO is empty. Sustained throughput is one per cycle with resp_ready held high.
- req_ready = (count + inflight) < FIFO_DEPTH. It is built from registers only, with no combinational path from resp_ready. This guarantees the FIFO never overflows.
- Pop: resp_valid and resp_ready at an edge advance the read pointer. Push and pop in the same edge leave count unchanged.
- Outputs with resp_valid=0 hold their last value; the bench must not check them then.
- Back-pressure: resp_ready=0 holds the head stable (all resp_* fields) until popped.
- Flush (sync, at its edge):
  - count clears to 0, pointers realign, any stage entry is discarded, and the pop is ignored;
  - a request accepted in the same cycle as flush is kept: it is the redirect target and enters the stage normally;
  - resp_valid is 0 in the cycle after a flush edge.
- Program load:
  - prog_we writes prog_data to array[prog_addr] at the edge;
  - a fetch of the same word in the same cycle returns the old data (read-before-write);
  - the load port is otherwise independent of fetch.
- Count width: log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-operation discards everything immediately. The first accept after release follows the latency rule above.

Decomposition:
- Shared package rv32i_pkg: NOP_INSTR constant, XLEN=32, and a fetch-response struct/field layout (addr, instr, misaligned, oob). Decode reuses these.
- One sub-module, resp_fifo: parameterised synchronous FIFO with flush, count and wrap. The array and stage stay in imem_responder.

Test Plan:
- Load words 0x00500093, 0x00a00113, 0x002081b3 at indices 0..2. Hold resp_ready=1 and request addrs 0x0, 0x4, 0x8 back-to-back from cycle 0. Expect resp_valid in cycles 2, 3, 4 with the matching instr/addr, no faults, req_ready constantly 1.
- Hold resp_ready=0 and issue requests until req_ready drops. Expect exactly FIFO_DEPTH accepts, then req_ready=0, and the head (addr 0x0) stable. Raise resp_ready: responses arrive in order with no loss or duplication.
- Request 0x6 -> resp_misaligned=1, resp_instr=0x00000013, resp_addr=0x6. Request 0x1000 with DEPTH=1024 -> resp_oob=1, NOP returned.
- Queue 3 responses with resp_ready=0. Pulse flush together with a request for 0x20. Expect no old responses; the next resp_valid carries addr 0x20 two cycles later.
- In one cycle, set prog_we to index 5 with 0xdeadbeef and fetch 0x14. Expect the old word. A fetch of 0x14 one cycle later returns 0xdeadbeef.
- Assert rst low mid-burst with 2 queued entries. Expect resp_valid=0 and req_ready=1 immediately (async). After release, a fetch of 0x0 responds after 2 cycles.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side definitions, reused by decode.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] instr;
        logic            misaligned;
        logic            oob;
    } fetch_resp_t;

    localparam int FETCH_RESP_W = $bits(fetch_resp_t);

endpackage

// File: rtl/imem_responder_resp_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from registered entries.
module resp_fifo #(
    parameter int W     = 66,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic [W-1:0]  entry [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Flush wins over both push and pop in its cycle.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count_reg != '0) && !flush;

    // Entries reset to zero so the head fields read as 0 out of reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [W-1:0] entry_reg;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                entry_reg <= '0;
            end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
                entry_reg <= push_data;
            end
        end
        assign entry[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_valid = (count_reg != '0);
    assign head_data  = entry[rd_ptr_reg];
    assign count      = count_reg;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: sync-read word array, one-cycle read stage, response FIFO to decode.
module imem_responder #(
    parameter int          DEPTH      = 1024,
    parameter int          AW         = 10,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INSTR  = rv32i_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [31:0]   req_addr,
    output logic          req_ready,
    input  logic          flush,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_addr,
    output logic [31:0]   resp_instr,
    output logic          resp_misaligned,
    output logic          resp_oob,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data
);
    import rv32i_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_data_reg;
    logic          stage_valid_reg;
    logic [31:0]   stage_addr_reg;
    logic          stage_mis_reg;
    logic          stage_oob_reg;

    logic          accept;
    logic          push;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] occupancy;
    fetch_resp_t   push_data;
    fetch_resp_t   head;

    // Counting the stage entry as occupied keeps the FIFO from overflowing
    // without looking at resp_ready.
    assign occupancy = SW'(fifo_count) + SW'(stage_valid_reg);
    assign req_ready = (occupancy < SW'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // Array is not reset; reading and writing in one block gives read-before-write.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
        if (accept)  rd_data_reg    <= mem[req_addr[AW+1:2]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid_reg <= 1'b0;
            stage_addr_reg  <= '0;
            stage_mis_reg   <= 1'b0;
            stage_oob_reg   <= 1'b0;
        end else begin
            stage_valid_reg <= accept;
            if (accept) begin
                stage_addr_reg <= req_addr;
                stage_mis_reg  <= |req_addr[1:0];
                stage_oob_reg  <= (req_addr[31:AW+2] != '0);
            end
        end
    end

    // A flush discards the entry sitting in the stage; a same-cycle accept survives.
    assign push = stage_valid_reg && !flush;

    always_comb begin
        push_data            = '0;
        push_data.addr       = stage_addr_reg;
        push_data.misaligned = stage_mis_reg;
        push_data.oob        = stage_oob_reg;
        push_data.instr      = (stage_mis_reg || stage_oob_reg) ? NOP_INSTR : rd_data_reg;
    end

    resp_fifo #(
        .W     ($bits(fetch_resp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_data  (push_data),
        .pop        (resp_ready),
        .head_valid (resp_valid),
        .head_data  (head),
        .count      (fifo_count)
    );

    assign resp_addr       = head.addr;
    assign resp_instr      = head.instr;
    assign resp_misaligned = head.misaligned;
    assign resp_oob        = head.oob;

endmodule
